pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 16-bit, 5-stage core.
- Drives enable/flush for the four pipeline buffers (fetch/decode, decode/ALU, ALU/mem, mem/WB) and the PC write enable and PC mux select.
- Handles load-use stalls, taken-branch flushes, two-cycle 32-bit memory accesses (PC push/pop) and the multi-cycle interrupt entry sequence.
- Sits beside the datapath. Inputs come from the fd, da and am buffer outputs and the ALU branch unit.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 3;

  // PC mux selections
  localparam logic [1:0] PC_SEL_NEXT   = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_INT    = 2'b10;
  localparam logic [1:0] PC_SEL_RESET  = 2'b11;

  // Controller state encoding
  localparam logic [2:0] ST_RUN         = 3'd0;
  localparam logic [2:0] ST_WIDE_HI     = 3'd1;
  localparam logic [2:0] ST_INT_DRAIN   = 3'd2;
  localparam logic [2:0] ST_INT_PUSH_LO = 3'd3;
  localparam logic [2:0] ST_INT_PUSH_HI = 3'd4;
  localparam logic [2:0] ST_INT_VEC     = 3'd5;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W
);
  logic             i_int;
  logic [REG_W-1:0] i_fd_Rsrc1;
  logic [REG_W-1:0] i_fd_Rsrc2;
  logic             i_fd_use1;
  logic             i_fd_use2;
  logic             i_da_mem_read;
  logic [REG_W-1:0] i_da_Rdst;
  logic             i_branch_taken;
  logic             i_am_wide;
  logic             o_pc_en;
  logic [1:0]       o_pc_sel;
  logic             o_fd_en;
  logic             o_fd_flush;
  logic             o_da_en;
  logic             o_da_flush;
  logic             o_am_en;
  logic             o_mw_en;
  logic             o_mw_flush;
  logic             o_mem_half;
  logic             o_int_push;
  logic             o_int_ack;

  // Datapath side: supplies stage status, consumes control
  modport master (
    output i_int, i_fd_Rsrc1, i_fd_Rsrc2, i_fd_use1, i_fd_use2,
           i_da_mem_read, i_da_Rdst, i_branch_taken, i_am_wide,
    input  o_pc_en, o_pc_sel, o_fd_en, o_fd_flush, o_da_en, o_da_flush,
           o_am_en, o_mw_en, o_mw_flush, o_mem_half, o_int_push, o_int_ack
  );

  // Controller side
  modport slave (
    input  i_int, i_fd_Rsrc1, i_fd_Rsrc2, i_fd_use1, i_fd_use2,
           i_da_mem_read, i_da_Rdst, i_branch_taken, i_am_wide,
    output o_pc_en, o_pc_sel, o_fd_en, o_fd_flush, o_da_en, o_da_flush,
           o_am_en, o_mw_en, o_mw_flush, o_mem_half, o_int_push, o_int_ack
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - load-use hazard comparator
module hazard_detect #(
  parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W
) (
  input  logic             mem_read,
  input  logic [REG_W-1:0] rdst,
  input  logic [REG_W-1:0] rsrc1,
  input  logic [REG_W-1:0] rsrc2,
  input  logic             use1,
  input  logic             use2,
  output logic             stall_lu
);
  // A load in ALU feeding a source the decode instruction actually reads
  assign stall_lu = mem_read && ((use1 && (rsrc1 == rdst)) || (use2 && (rsrc2 == rdst)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline enable/flush, PC select and interrupt entry FSM
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave bus
);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ret_drain, ret_drain_nxt;
  logic             stall_lu;
  logic             run_events, drain_step, wide_first;

  logic       pc_en, fd_en, fd_flush, da_en, da_flush, am_en, mw_en, mw_flush;
  logic       mem_half, int_push, int_ack;
  logic [1:0] pc_sel;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .mem_read (bus.i_da_mem_read),
    .rdst     (bus.i_da_Rdst),
    .rsrc1    (bus.i_fd_Rsrc1),
    .rsrc2    (bus.i_fd_Rsrc2),
    .use1     (bus.i_fd_use1),
    .use2     (bus.i_fd_use2),
    .stall_lu (stall_lu)
  );

  // Classify the cycle: first half of a wide access, a normal RUN-style cycle,
  // or a drain cycle (WIDE_HI returns to draining when it interrupted a drain)
  always_comb begin
    wide_first = bus.i_am_wide && ((state == ST_RUN) || (state == ST_INT_DRAIN));
    run_events = ((state == ST_RUN) && !bus.i_am_wide) || ((state == ST_WIDE_HI) && !ret_drain);
    drain_step = ((state == ST_INT_DRAIN) && !bus.i_am_wide) || ((state == ST_WIDE_HI) && ret_drain);
  end

  // Output muxing and next-state selection
  always_comb begin
    pc_en = 1'b1; pc_sel = PC_SEL_NEXT;
    fd_en = 1'b1; fd_flush = 1'b0;
    da_en = 1'b1; da_flush = 1'b0;
    am_en = 1'b1; mw_en = 1'b1; mw_flush = 1'b0;
    mem_half = (state == ST_WIDE_HI) || (state == ST_INT_PUSH_HI);
    int_push = 1'b0; int_ack = 1'b0;
    state_nxt = state; cnt_nxt = cnt; ret_drain_nxt = ret_drain;

    if (wide_first) begin
      // Freeze everything upstream of mem while the low half is accessed
      pc_en = 1'b0; fd_en = 1'b0; da_en = 1'b0; am_en = 1'b0; mw_flush = 1'b1;
      ret_drain_nxt = (state == ST_INT_DRAIN);
      state_nxt = ST_WIDE_HI;
    end

    if (run_events) begin
      state_nxt = ST_RUN;
      if (bus.i_branch_taken) begin
        pc_sel = PC_SEL_BRANCH; fd_flush = 1'b1; da_flush = 1'b1;
      end else if (stall_lu) begin
        pc_en = 1'b0; fd_en = 1'b0; da_flush = 1'b1;
      end else if ((state == ST_RUN) && bus.i_int) begin
        state_nxt = ST_INT_DRAIN;
        cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
      end
    end

    if (drain_step) begin
      // Stop fetching; a late branch still redirects so the saved PC is its target
      pc_en = 1'b0; fd_flush = 1'b1;
      if (bus.i_branch_taken) begin
        pc_sel = PC_SEL_BRANCH; pc_en = 1'b1; da_flush = 1'b1;
      end
      if (cnt == '0) begin
        state_nxt = ST_INT_PUSH_LO;
      end else begin
        state_nxt = ST_INT_DRAIN;
        cnt_nxt = cnt - CNT_W'(1);
      end
    end

    case (state)
      ST_INT_PUSH_LO: begin
        int_push = 1'b1; pc_en = 1'b0; fd_flush = 1'b1; da_flush = 1'b1;
        state_nxt = ST_INT_PUSH_HI;
      end
      ST_INT_PUSH_HI: begin
        int_push = 1'b1; pc_en = 1'b0; fd_flush = 1'b1; da_flush = 1'b1;
        state_nxt = ST_INT_VEC;
      end
      ST_INT_VEC: begin
        pc_sel = PC_SEL_INT; fd_flush = 1'b1; int_ack = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN, ST_WIDE_HI, ST_INT_DRAIN: ;
      default: state_nxt = ST_RUN;
    endcase

    if (rst) begin
      pc_en = 1'b0; pc_sel = PC_SEL_RESET;
      fd_en = 1'b0; fd_flush = 1'b1;
      da_en = 1'b0; da_flush = 1'b1;
      am_en = 1'b0; mw_en = 1'b0; mw_flush = 1'b1;
      mem_half = 1'b0; int_push = 1'b0; int_ack = 1'b0;
    end
  end

  // State, drain counter and wide-return flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      ret_drain <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ret_drain <= ret_drain_nxt;
    end
  end

  assign bus.o_pc_en    = pc_en;
  assign bus.o_pc_sel   = pc_sel;
  assign bus.o_fd_en    = fd_en;
  assign bus.o_fd_flush = fd_flush;
  assign bus.o_da_en    = da_en;
  assign bus.o_da_flush = da_flush;
  assign bus.o_am_en    = am_en;
  assign bus.o_mw_en    = mw_en;
  assign bus.o_mw_flush = mw_flush;
  assign bus.o_mem_half = mem_half;
  assign bus.o_int_push = int_push;
  assign bus.o_int_ack  = int_ack;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int D = 3;

  // Output word: {pc_en, pc_sel[1:0], fd_en, fd_flush, da_en, da_flush, am_en, mw_en, mw_flush, mem_half, int_push, int_ack}
  localparam logic [12:0] DEF = 13'b1_00_1_0_1_0_1_1_0_0_0_0;
  localparam logic [12:0] STL = 13'b0_00_0_0_1_1_1_1_0_0_0_0;
  localparam logic [12:0] BRN = 13'b1_01_1_1_1_1_1_1_0_0_0_0;
  localparam logic [12:0] WID = 13'b0_00_0_0_0_0_0_1_1_0_0_0;
  localparam logic [12:0] BRH = 13'b1_01_1_1_1_1_1_1_0_1_0_0;
  localparam logic [12:0] RSO = 13'b0_11_0_1_0_1_0_0_1_0_0_0;
  localparam logic [12:0] DRN = 13'b0_00_1_1_1_0_1_1_0_0_0_0;
  localparam logic [12:0] PLO = 13'b0_00_1_1_1_1_1_1_0_0_1_0;
  localparam logic [12:0] PHI = 13'b0_00_1_1_1_1_1_1_0_1_1_0;
  localparam logic [12:0] VEC = 13'b1_10_1_1_1_0_1_1_0_0_0_1;

  typedef struct {
    logic       irq;
    logic [2:0] s1, s2;
    logic       u1, u2, mr;
    logic [2:0] rd;
    logic       br, wide;
  } in_t;

  typedef struct {
    in_t         in;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  in_t cur;

  pipe_hazard_ctrl_if #(.REG_W(3)) bus ();
  pipe_hazard_ctrl #(.REG_W(3), .DRAIN_CYCLES(D), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model: interrupt sequence as a cycle position, plus a pending wide second half
  bit m_in_int = 0;
  int m_seq = 0;
  bit m_wide2 = 0;

  function automatic logic is_lu(input in_t v);
    return v.mr && ((v.u1 && v.s1 == v.rd) || (v.u2 && v.s2 == v.rd));
  endfunction

  function automatic logic [12:0] model_out(input logic r, input in_t v);
    logic pe, fe, ff, de, df, ae, me, mf, mh, ip, ia;
    logic [1:0] ps;
    pe = 1; ps = 0; fe = 1; ff = 0; de = 1; df = 0; ae = 1; me = 1; mf = 0; mh = 0; ip = 0; ia = 0;
    if (r) return RSO;
    if (!m_in_int || m_seq < D) begin
      if (!m_wide2 && v.wide) begin
        pe = 0; fe = 0; de = 0; ae = 0; mf = 1;
      end else if (!m_in_int) begin
        mh = m_wide2;
        if (v.br) begin ps = 1; ff = 1; df = 1; end
        else if (is_lu(v)) begin pe = 0; fe = 0; df = 1; end
      end else begin
        mh = m_wide2; pe = 0; ff = 1;
        if (v.br) begin ps = 1; pe = 1; df = 1; end
      end
    end else if (m_seq == D || m_seq == D + 1) begin
      ip = 1; mh = (m_seq == D + 1); pe = 0; ff = 1; df = 1;
    end else begin
      ps = 2; ff = 1; ia = 1;
    end
    return {pe, ps, fe, ff, de, df, ae, me, mf, mh, ip, ia};
  endfunction

  task automatic model_next(input in_t v, output bit ii, output int sq, output bit w2);
    ii = m_in_int; sq = m_seq; w2 = m_wide2;
    if (!m_in_int) begin
      if (m_wide2) w2 = 0;
      else if (v.wide) w2 = 1;
      else if (!v.br && !is_lu(v) && v.irq) begin ii = 1; sq = 0; end
    end else if (m_seq < D) begin
      if (!m_wide2 && v.wide) w2 = 1;
      else begin w2 = 0; sq = m_seq + 1; end
    end else if (m_seq == D + 2) begin
      ii = 0; sq = 0;
    end else begin
      sq = m_seq + 1;
    end
  endtask

  // Advance the model with the inputs held across the edge
  always @(posedge clk or posedge rst) begin
    bit ii, w2;
    int sq;
    if (rst) begin
      m_in_int <= 0; m_seq <= 0; m_wide2 <= 0;
    end else begin
      model_next(cur, ii, sq, w2);
      m_in_int <= ii; m_seq <= sq; m_wide2 <= w2;
    end
  end

  function automatic in_t mk(input logic irq, input int s1, input int s2, input logic u1, input logic u2,
                             input logic mr, input int rd, input logic br, input logic wide);
    in_t v;
    v.irq = irq; v.s1 = 3'(s1); v.s2 = 3'(s2); v.u1 = u1; v.u2 = u2;
    v.mr = mr; v.rd = 3'(rd); v.br = br; v.wide = wide;
    return v;
  endfunction

  task automatic drive(input in_t v);
    cur = v;
    bus.i_int = v.irq; bus.i_fd_Rsrc1 = v.s1; bus.i_fd_Rsrc2 = v.s2;
    bus.i_fd_use1 = v.u1; bus.i_fd_use2 = v.u2; bus.i_da_mem_read = v.mr;
    bus.i_da_Rdst = v.rd; bus.i_branch_taken = v.br; bus.i_am_wide = v.wide;
  endtask

  function automatic logic [12:0] dut_outs();
    return {bus.o_pc_en, bus.o_pc_sel, bus.o_fd_en, bus.o_fd_flush, bus.o_da_en, bus.o_da_flush,
            bus.o_am_en, bus.o_mw_en, bus.o_mw_flush, bus.o_mem_half, bus.o_int_push, bus.o_int_ack};
  endfunction

  task automatic check(input string nm, input logic [12:0] exp);
    logic [12:0] act;
    act = dut_outs();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic cyc(input in_t v, input string nm, input logic [12:0] exp);
    @(negedge clk);
    drive(v);
    #1;
    check(nm, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("reset_outs", RSO);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[10];
  in_t  idle, irq1, rv;
  logic [12:0] e;
  logic irq_req;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    irq1 = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);

    tbl[0] = '{mk(0, 1, 2, 1, 1, 0, 5, 0, 0), DEF};
    tbl[1] = '{mk(0, 0, 3, 0, 1, 1, 3, 0, 0), STL};
    tbl[2] = '{mk(0, 0, 3, 0, 0, 1, 3, 0, 0), DEF};
    tbl[3] = '{mk(0, 5, 1, 1, 0, 1, 5, 0, 0), STL};
    tbl[4] = '{mk(0, 5, 5, 1, 1, 0, 5, 0, 0), DEF};
    tbl[5] = '{mk(0, 0, 3, 0, 1, 1, 3, 1, 0), BRN};
    tbl[6] = '{mk(0, 2, 4, 1, 1, 0, 7, 1, 0), BRN};
    tbl[7] = '{mk(0, 0, 3, 0, 1, 1, 3, 1, 1), WID};
    tbl[8] = '{mk(1, 1, 2, 1, 1, 0, 0, 0, 0), DEF};
    tbl[9] = '{mk(1, 6, 2, 1, 0, 1, 6, 0, 0), STL};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      cyc(tbl[i].in, $sformatf("vec%0d", i), tbl[i].exp);
    end

    // Full interrupt entry, then a held request re-entering after one RUN cycle
    do_reset();
    cyc(irq1, "int_run", DEF);
    for (int i = 0; i < D; i++) cyc(irq1, $sformatf("int_drain%0d", i), DRN);
    cyc(irq1, "int_push_lo", PLO);
    cyc(irq1, "int_push_hi", PHI);
    cyc(irq1, "int_vec", VEC);
    cyc(irq1, "int_reenter_run", DEF);
    cyc(irq1, "int_reenter_drain", DRN);

    // Branch on the second drain cycle keeps drain length
    do_reset();
    cyc(irq1, "dbr_run", DEF);
    cyc(irq1, "dbr_drain0", DRN);
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), "dbr_drain1_branch", BRN);
    cyc(irq1, "dbr_drain2", DRN);
    cyc(irq1, "dbr_push_lo", PLO);

    // Wide access masks a branch in its first half, honours it in the second
    do_reset();
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), "wide_lo", WID);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), "wide_hi_branch", BRH);
    cyc(idle, "wide_after", DEF);

    // Reset in the middle of the push aborts immediately
    do_reset();
    cyc(irq1, "rmid_run", DEF);
    for (int i = 0; i < D; i++) cyc(irq1, $sformatf("rmid_drain%0d", i), DRN);
    cyc(irq1, "rmid_push_lo", PLO);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmid_reset", RSO);
    @(negedge clk);
    rst = 1'b0;
    drive(idle);
    #1;
    check("rmid_release", DEF);

    // Randomised run against the reference model
    do_reset();
    irq_req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      rv.irq  = irq_req;
      rv.s1   = 3'($urandom_range(0, 3));
      rv.s2   = 3'($urandom_range(0, 3));
      rv.rd   = 3'($urandom_range(0, 3));
      rv.u1   = 1'($urandom_range(0, 1));
      rv.u2   = 1'($urandom_range(0, 1));
      rv.mr   = ($urandom_range(0, 2) == 0);
      rv.br   = ($urandom_range(0, 5) == 0);
      rv.wide = ($urandom_range(0, 7) == 0);
      drive(rv);
      #1;
      e = model_out(rst, rv);
      check($sformatf("rand%0d", i), e);
      if (e[0]) irq_req = 1'b0;
      else if (!irq_req && $urandom_range(0, 9) == 0) irq_req = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
